keypad_emulator: RTL

Synthesizable 4x4 matrix-keypad emulator: the passive keypad end of the row/column keypad interface used by the door-lock top. It accepts key codes through a valid/ready handshake, queues them in a FIFO and "presses" each key for a timed interval, answering the scanner's row drive on the column lines. It is used on GPIO loopback and in benches so the lock's scanner can run unmodified against scripted key sequences.

---
 rtl/keypad_emulator.sv | 126 ++++++++++++
 1 files changed

// File: rtl/keypad_emulator.sv
// Passive 4x4 matrix-keypad emulator: queues key codes and presses each one for a timed interval.
// Optional contact bounce at press start is enabled with `define KEYEMU_BOUNCE_EN.
module keypad_emulator #(
  parameter int FIFO_DEPTH     = 8,
  parameter int PRESS_CYCLES   = 50,
  parameter int RELEASE_CYCLES = 50,
  parameter int BOUNCE_CYCLES  = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [3:0]                        lin,
  output logic [3:0]                        col,
  input  logic [3:0]                        key_in,
  input  logic                              key_valid,
  output logic                              key_ready,
  input  logic                              flush,
  output logic                              pressing,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   key_count,
  output logic [3:0]                        cur_key
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int KW   = $clog2(FIFO_DEPTH+1);
  localparam int MAXC = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
  localparam int CW   = $clog2(MAXC+1);

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_RELEASE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [3:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [KW-1:0]   count;
  logic            push, pop;
  logic            next_contact;

  assign key_ready = rst && (count < KW'(FIFO_DEPTH));
  assign push      = key_valid && key_ready && !flush;
  assign pop       = (state == S_IDLE) && (count != '0) && !flush;
  assign key_count = count;
  assign busy      = (state != S_IDLE) || (count != '0);

  // Only the row of the held key matters, so multiple driven rows never ghost.
  always_comb begin
    col = 4'hF;
    if (pressing && !lin[cur_key[3:2]])
      col[cur_key[1:0]] = 1'b0;
  end

`ifdef KEYEMU_BOUNCE_EN
  logic [CW-1:0] offset;
  // Press offset of the next cycle; contact is open on odd offsets inside the bounce window.
  assign offset       = CW'(PRESS_CYCLES) - cnt;
  assign next_contact = (offset >= CW'(BOUNCE_CYCLES)) || !offset[0];
`else
  assign next_contact = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= key_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      cur_key  <= '0;
      pressing <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            cur_key  <= mem[rd_ptr];
            cnt      <= CW'(PRESS_CYCLES-1);
            state    <= S_PRESS;
            pressing <= 1'b1;
          end else begin
            cur_key  <= '0;
          end
        end
        S_PRESS: begin
          if (flush || cnt == '0) begin
            state    <= S_RELEASE;
            cnt      <= CW'(RELEASE_CYCLES-1);
            pressing <= 1'b0;
          end else begin
            cnt      <= cnt - 1'b1;
            pressing <= next_contact;
          end
        end
        S_RELEASE: begin
          if (cnt == '0) begin
            state   <= S_IDLE;
            cur_key <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          pressing <= 1'b0;
        end
      endcase
    end
  end

endmodule
